// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one result bit per clock.
// Start/busy/done handshake; digits above 9 are flagged through err and return 0.
module bcd2bin_seq #(
   parameter int unsigned N_DIG = 2,
   parameter int unsigned W     = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [4*N_DIG-1:0] bcd_in,
   output logic               busy,
   output logic               done,
   output logic [W-1:0]       bin_out,
   output logic               err
);

   localparam int unsigned BW = 4 * N_DIG;
   localparam int unsigned SW = BW + W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [SW-1:0] sreg;
   logic [SW-1:0] sreg_nx;
   logic [SW-1:0] sreg_step;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   logic [W-1:0]  bin_nx;
   logic          err_nx;
   logic          bad_digit;

   always_comb begin : digit_check
      bad_digit = 1'b0;
      for (int unsigned i = 0; i < N_DIG; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // One iteration: shift right, then every BCD digit that reached 8 or more
   // had a ten's weight shifted into it and loses 3 to stay a valid digit.
   always_comb begin : iteration
      sreg_step = {1'b0, sreg[SW-1:1]};
      for (int unsigned i = 0; i < N_DIG; i++) begin
         if (sreg_step[W+4*i +: 4] >= 4'd8) begin
            sreg_step[W+4*i +: 4] = sreg_step[W+4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin : next_state
      state_nx = state;
      sreg_nx  = sreg;
      count_nx = count;
      bin_nx   = bin_out;
      err_nx   = err;
      case (state)
         IDLE: begin
            if (start) begin
               if (bad_digit) begin
                  state_nx = DONE;
                  bin_nx   = '0;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = SHIFT;
                  sreg_nx  = {bcd_in, {W{1'b0}}};
                  count_nx = '0;
               end
            end
         end
         SHIFT: begin
            sreg_nx = sreg_step;
            if (count == LAST) begin
               state_nx = DONE;
               bin_nx   = sreg_step[W-1:0];
               err_nx   = 1'b0;
            end else begin
               count_nx = count + 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // busy/done are registered from the next state so they come straight off flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sreg    <= '0;
         count   <= '0;
         bin_out <= '0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         sreg    <= sreg_nx;
         count   <= count_nx;
         bin_out <= bin_nx;
         err     <= err_nx;
         busy    <= (state_nx != IDLE);
         done    <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed handshake cases, exhaustive valid sweep
// and random requests, all checked against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

   localparam int unsigned N_DIG = 2;
   localparam int unsigned W     = 7;

   logic             clk;
   logic             reset;
   logic             start;
   logic [4*N_DIG-1:0] bcd_in;
   logic             busy;
   logic             done;
   logic [W-1:0]     bin_out;
   logic             err;

   int n_tests = 0;
   int n_fail  = 0;

   bcd2bin_seq #(
      .N_DIG(N_DIG),
      .W    (W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .bcd_in (bcd_in),
      .busy   (busy),
      .done   (done),
      .bin_out(bin_out),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of the digits, or error with zero result.
   function automatic void model(input logic [4*N_DIG-1:0] b, output logic [W-1:0] bin,
                                 output logic e);
      int v;
      int scale;
      int d;
      v     = 0;
      scale = 1;
      e     = 1'b0;
      for (int i = 0; i < int'(N_DIG); i++) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) e = 1'b1;
         v     = v + d * scale;
         scale = scale * 10;
      end
      bin = e ? '0 : W'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one single-cycle start request and checks latency, busy length and result.
   task automatic run_conv(input logic [4*N_DIG-1:0] b, input string tag);
      logic [W-1:0] exp_bin;
      logic         exp_err;
      int           lat;
      int           busy_cyc;
      logic         seen;
      model(b, exp_bin, exp_err);
      bcd_in = b;
      start  = 1'b1;
      tick();
      start    = 1'b0;
      bcd_in   = 8'($urandom);
      lat      = 0;
      busy_cyc = 0;
      seen     = 1'b0;
      for (int k = 0; k <= 20 && !seen; k++) begin
         if (busy) busy_cyc++;
         if (done) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            tick();
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), exp_err ? 32'd0 : 32'(W));
      check({tag, "_busy_cycles"}, 32'(busy_cyc), exp_err ? 32'd1 : 32'(W + 1));
      check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      tick();
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dones;
      int last;
      logic [W-1:0] eb;
      logic         ee;

      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bin", 32'(bin_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      run_conv(8'h42, "c42");
      run_conv(8'h99, "c99");
      run_conv(8'h00, "c00");
      run_conv(8'h10, "c10");
      run_conv(8'h3A, "c3A");
      run_conv(8'hA0, "cA0");

      for (int t = 0; t < 100; t++) begin
         logic [7:0] b;
         b = {4'(t / 10), 4'(t % 10)};
         run_conv(b, "sweep");
      end

      for (int t = 0; t < 40; t++) begin
         run_conv(8'($urandom), "rand");
      end

      // start pulses while busy must not be queued or converted
      bcd_in = 8'h25;
      start  = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k >= 2 && k <= 6) begin
            start  = (k % 2 == 0);
            bcd_in = 8'h77;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dones++;
            check("ign_bin", 32'(bin_out), 32'd25);
            check("ign_err", 32'(err), 32'd0);
         end
         tick();
      end
      check("ign_dones", 32'(dones), 32'd1);
      check("ign_idle", 32'(busy), 32'd0);
      check("ign_bin_hold", 32'(bin_out), 32'd25);

      // reset in the middle of a conversion
      run_conv(8'h99, "pre_rst");
      bcd_in = 8'h58;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_bin", 32'(bin_out), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      #2;
      reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done || busy) dones++;
      end
      check("post_rst_quiet", 32'(dones), 32'd0);
      run_conv(8'h13, "c13");

      // start held high: one conversion every W+2 cycles
      model(8'h64, eb, ee);
      bcd_in = 8'h64;
      start  = 1'b1;
      dones  = 0;
      last   = -1;
      for (int c = 0; c < 48; c++) begin
         tick();
         if (done) begin
            check("held_bin", 32'(bin_out), 32'(eb));
            check("held_err", 32'(err), 32'(ee));
            if (last >= 0) check("held_period", 32'(c - last), 32'(W + 2));
            last = c;
            dones++;
         end
      end
      check("held_count", 32'(dones >= 4), 32'd1);
      start = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      check("held_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential BCD-to-binary converter: accepts an N-digit packed BCD word on a start strobe and produces the equivalent unsigned binary value using reverse double-dabble, one bit per clock. It is the inverse of the combinational binary-to-BCD path feeding the seven-segment display. It converts keypad or switch entries in BCD back into binary operands for the arithmetic datapath. A start/busy/done handshake lets a controller FSM sequence it.

## Interface

- N_DIG, 2: number of BCD digits in the input word.
- W, 7: binary output width. Must satisfy 2^W > 10^N_DIG − 1; default covers 0..99.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*N_DIG  packed BCD, digit 0 (ones) in bits [3:0]; sampled on the accepting edge only.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse: bin_out/err valid and updated.
- bin_out  output  W  converted value; holds until next done.
- err  output  1  last request contained a digit > 9; holds with bin_out.

## Operation

- Working register sreg = {bcd_part (4*N_DIG bits), bin_part (W bits)}; iteration counter 0..W−1.
- States:
  - IDLE: busy=0. On start=1:
    - If any digit of bcd_in > 9, go to DONE with err_next=1 and result 0.
    - Otherwise load bcd_part=bcd_in, bin_part=0, count=0, and go to SHIFT.
  - SHIFT: each edge performs one iteration:
    - Shift sreg right by 1; 0 enters the MSB, and the bcd_part LSB moves into the bin_part MSB.
    - Then, for every digit of the shifted bcd_part, if digit ≥ 8, subtract 3 (all digits corrected in the same cycle, computed from the shifted value).
    - When count = W−1, go to DONE; otherwise count+1.
  - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- bin_out and err are registered and update on the edge entering DONE:
  - Valid request: bin_out=bin_part, err=0.
  - Invalid request: bin_out=0, err=1.
- After W iterations with valid input, bcd_part is all zero. The implementation need not check this.
- start is ignored while busy=1, including the DONE cycle; no queuing.
- bcd_in changes after the accepting edge have no effect.

## Timing

- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bin_out=0, err=0, sreg=0, count=0.
- Cycle numbering: start sampled at edge E0.
- Valid conversion:
  - busy rises after E0.
  - Iterations occur at E1..EW; state enters DONE at EW.
  - done=1 and bin_out valid during the cycle after EW.
  - Back in IDLE after EW+1.
  - Start-to-done latency: W cycles (default 7). Throughput: one conversion per W+2 cycles.
- Invalid conversion: DONE entered at E0; done=1 in the cycle after E0, err=1; back to IDLE after E1.
- start held continuously high: a new conversion is accepted on the first IDLE edge after each DONE.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values, no done pulse. A pending done is lost, and previous bin_out/err are cleared.
- busy and done are Moore outputs, glitch-free registered decode of state.

## Test plan

- Reset, then bcd_in=0x42, one-cycle start → busy high for 8 cycles; done pulses once exactly 7 cycles after the start edge; bin_out=42 (0x2A), err=0.
- bcd_in=0x99 → bin_out=99 (0x63). bcd_in=0x00 → bin_out=0. bcd_in=0x10 → bin_out=10. Each err=0. Also run an exhaustive sweep of all 100 valid inputs against a reference model.
- bcd_in=0x3A, start → done one cycle after the start edge, err=1, bin_out=0, busy high for 1 cycle only.
- Start 0x25; at cycles 2–6 pulse start with bcd_in=0x77 → exactly one done, bin_out=25. 0x77 is never converted.
- Start 0x58; assert reset at cycle 4 → all outputs 0 at once, no done. Release, then start 0x13 → bin_out=13 after 7 cycles.
- start tied high with bcd_in=0x64 → done every 9 cycles, bin_out=64 each time, err=0.
